// File: rtl/decode_queue.sv
// Pre-decoding instruction FIFO between fetch and issue; head fields are registered.
// Define DEC_MEXT_EN to decode the M extension (op, funct7=0000001) as alu_mstd.
module decode_queue #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [31:0]         IN_INS,
    input  logic [PC_WIDTH-1:0] IN_PC,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [31:0]         OUT_INS,
    output logic [PC_WIDTH-1:0] OUT_PC,
    output logic [3:0]          ALU_CNT,
    output logic [1:0]          D_CACHE_CONTROL,
    output logic [2:0]          FUN3,
    output logic [3:0]          CSR_CNT,
    output logic                JUMP,
    output logic                JUMPR,
    output logic                CBRANCH,
    output logic [1:0]          TYPE,
    output logic                A_BUS_SEL,
    output logic                B_BUS_SEL,
    output logic                ILLEGAL,
    output logic [CNT_W-1:0]    COUNT
);
    localparam int PTR_W = $clog2(DEPTH);

`ifdef DEC_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    localparam logic [3:0] ALU_IDLE = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3,  ALU_SLT  = 4'd4,  ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6,  ALU_SRL  = 4'd7,  ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9,  ALU_AND  = 4'd10, ALU_A   = 4'd11;
    localparam logic [3:0] ALU_B4   = 4'd12, ALU_CSR  = 4'd13, ALU_MSTD = 4'd14;

    localparam logic [3:0] SYS_ECALL = 4'd1, SYS_EBREAK = 4'd2, SYS_URET = 4'd3;
    localparam logic [3:0] SYS_SRET  = 4'd4, SYS_MRET   = 4'd5, SYS_WFI  = 4'd6;
    localparam logic [3:0] SYS_CSRRW = 4'd7, SYS_CSRRS  = 4'd8, SYS_CSRRC = 4'd9;
    localparam logic [3:0] SYS_CSRRWI = 4'd10, SYS_CSRRSI = 4'd11, SYS_CSRRCI = 4'd12;

    localparam logic [1:0] T_ALU = 2'd1, T_LD = 2'd2;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL = 7'b1101111, OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR  = 7'b1100011, OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011, OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP  = 7'b0110011, OPC_SYS   = 7'b1110011;

    typedef struct packed {
        logic [31:0]         ins;
        logic [PC_WIDTH-1:0] pc;
        logic [3:0]          alu;
        logic [1:0]          dc;
        logic [3:0]          csr;
        logic                jump;
        logic                jumpr;
        logic                cbr;
        logic [1:0]          typ;
        logic                asel;
        logic                bsel;
        logic                ill;
    } ent_t;

    ent_t             dec;
    ent_t             hd;
    ent_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [3:0]       base_alu;

    assign opc = IN_INS[6:0];
    assign f3  = IN_INS[14:12];
    assign f7  = IN_INS[31:25];

    always_comb begin
        base_alu = ALU_ADD;
        case (f3)
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            3'd7:    base_alu = ALU_AND;
            default: base_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.ins = IN_INS;
        dec.pc  = IN_PC;
        case (opc)
            OPC_LUI:   begin dec.alu = ALU_A;   dec.typ = T_ALU; end
            OPC_AUIPC: begin dec.alu = ALU_ADD; dec.typ = T_ALU; end
            OPC_JAL:   begin dec.alu = ALU_B4;  dec.typ = T_ALU; dec.jump  = 1'b1; end
            OPC_JALR:  begin dec.alu = ALU_B4;  dec.typ = T_ALU; dec.jumpr = 1'b1; end
            OPC_BR:    begin dec.asel = 1'b1; dec.bsel = 1'b1; dec.cbr = 1'b1; end
            OPC_LD: begin
                dec.bsel = 1'b1; dec.alu = ALU_ADD; dec.typ = T_LD; dec.dc = 2'b01;
            end
            OPC_ST: begin
                dec.bsel = 1'b1; dec.alu = ALU_ADD; dec.dc = 2'b10;
            end
            OPC_OPI: begin
                dec.bsel = 1'b1;
                dec.typ  = T_ALU;
                dec.alu  = base_alu;
                if (f3 == 3'd1 && f7 != 7'h00) dec.ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) dec.alu = ALU_SRA;
                    else if (f7 != 7'h00) dec.ill = 1'b1;
                end
            end
            OPC_OP: begin
                dec.asel = 1'b1;
                dec.bsel = 1'b1;
                dec.typ  = T_ALU;
                case (f7)
                    7'h00: dec.alu = base_alu;
                    7'h20: begin
                        if (f3 == 3'd0)      dec.alu = ALU_SUB;
                        else if (f3 == 3'd5) dec.alu = ALU_SRA;
                        else                 dec.ill = 1'b1;
                    end
                    7'h01: begin
                        if (MEXT) dec.alu = ALU_MSTD;
                        else      dec.ill = 1'b1;
                    end
                    default: dec.ill = 1'b1;
                endcase
            end
            OPC_SYS: begin
                dec.alu = ALU_CSR;
                dec.typ = T_ALU;
                case (f3)
                    3'd0: begin
                        dec.typ = 2'd0;
                        case (IN_INS[31:20])
                            12'h000: dec.csr = SYS_ECALL;
                            12'h001: dec.csr = SYS_EBREAK;
                            12'h002: dec.csr = SYS_URET;
                            12'h102: dec.csr = SYS_SRET;
                            12'h302: dec.csr = SYS_MRET;
                            12'h105: dec.csr = SYS_WFI;
                            default: dec.ill = 1'b1;
                        endcase
                    end
                    3'd1:    dec.csr = SYS_CSRRW;
                    3'd2:    dec.csr = SYS_CSRRS;
                    3'd3:    dec.csr = SYS_CSRRC;
                    3'd5:    dec.csr = SYS_CSRRWI;
                    3'd6:    dec.csr = SYS_CSRRSI;
                    3'd7:    dec.csr = SYS_CSRRCI;
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = (IN_INS != 32'd0);
        endcase
        // Undefined encodings travel with every control field idle.
        if (dec.ill) begin
            dec.alu   = ALU_IDLE;
            dec.dc    = 2'b00;
            dec.csr   = 4'd0;
            dec.jump  = 1'b0;
            dec.jumpr = 1'b0;
            dec.cbr   = 1'b0;
            dec.typ   = 2'd0;
            dec.asel  = 1'b0;
            dec.bsel  = 1'b0;
        end
    end

    assign OUT_VALID = (cnt_q != '0);
    assign IN_READY  = (cnt_q < CNT_W'(DEPTH)) & ~FLUSH;
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign COUNT     = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (FLUSH) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= dec;
    end

    // Idle encodings are all-zero, so an empty queue presents a zero entry.
    assign hd = OUT_VALID ? mem_q[rd_q] : '0;

    assign OUT_INS         = hd.ins;
    assign OUT_PC          = hd.pc;
    assign ALU_CNT         = hd.alu;
    assign D_CACHE_CONTROL = hd.dc;
    assign FUN3            = hd.ins[14:12];
    assign CSR_CNT         = hd.csr;
    assign JUMP            = hd.jump;
    assign JUMPR           = hd.jumpr;
    assign CBRANCH         = hd.cbr;
    assign TYPE            = hd.typ;
    assign A_BUS_SEL       = hd.asel;
    assign B_BUS_SEL       = hd.bsel;
    assign ILLEGAL         = hd.ill;
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic
// compared against a queue model with an instruction-level decode reference.
module tb_decode_queue;
    localparam logic [3:0] ALU_IDLE = 0, ALU_ADD = 1, ALU_SUB = 2, ALU_SLL = 3;
    localparam logic [3:0] ALU_SLT = 4, ALU_SLTU = 5, ALU_XOR = 6, ALU_SRL = 7;
    localparam logic [3:0] ALU_SRA = 8, ALU_OR = 9, ALU_AND = 10, ALU_A = 11;
    localparam logic [3:0] ALU_B4 = 12, ALU_CSR = 13, ALU_MSTD = 14;
    localparam logic [3:0] SYS_MRET = 5;
    localparam logic [1:0] T_IDLE = 0, T_ALU = 1, T_LD = 2;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] csr;
        logic [1:0] typ;
        logic [1:0] dc;
        logic       jump, jumpr, cbr, asel, bsel, ill;
    } exp_t;

    logic        CLK = 0, RST_N = 0, FLUSH = 0, IN_VALID = 0, OUT_READY = 0;
    logic [31:0] IN_INS = 0, IN_PC = 0;
    logic        IN_READY, OUT_VALID, JUMP, JUMPR, CBRANCH, A_BUS_SEL, B_BUS_SEL, ILLEGAL;
    logic [31:0] OUT_INS, OUT_PC;
    logic [3:0]  ALU_CNT, CSR_CNT;
    logic [1:0]  D_CACHE_CONTROL, TYPE;
    logic [2:0]  FUN3;
    logic [2:0]  COUNT;

    int errors = 0;
    int checks = 0;
    logic [31:0] mq_ins[$];
    logic [31:0] mq_pc[$];
    logic        obs_rdy, exp_rdy;
    logic [3:0]  base_tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                  ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [3:0]  csr_tbl [8] = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd0, 4'd10, 4'd11, 4'd12};

    decode_queue dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INS(IN_INS), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INS(OUT_INS), .OUT_PC(OUT_PC),
        .ALU_CNT(ALU_CNT), .D_CACHE_CONTROL(D_CACHE_CONTROL), .FUN3(FUN3),
        .CSR_CNT(CSR_CNT), .JUMP(JUMP), .JUMPR(JUMPR), .CBRANCH(CBRANCH),
        .TYPE(TYPE), .A_BUS_SEL(A_BUS_SEL), .B_BUS_SEL(B_BUS_SEL),
        .ILLEGAL(ILLEGAL), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t e;
        logic ok;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [11:0] i12 = w[31:20];
        e = '0;
        ok = 1'b1;
        if (w == 0) return e;
        if (opc == 7'b0110111) begin e.alu = ALU_A; e.typ = T_ALU; end
        else if (opc == 7'b0010111) begin e.alu = ALU_ADD; e.typ = T_ALU; end
        else if (opc == 7'b1101111) begin e.alu = ALU_B4; e.typ = T_ALU; e.jump = 1; end
        else if (opc == 7'b1100111) begin e.alu = ALU_B4; e.typ = T_ALU; e.jumpr = 1; end
        else if (opc == 7'b1100011) begin e.asel = 1; e.bsel = 1; e.cbr = 1; end
        else if (opc == 7'b0000011) begin e.bsel = 1; e.alu = ALU_ADD; e.typ = T_LD; e.dc = 2'b01; end
        else if (opc == 7'b0100011) begin e.bsel = 1; e.alu = ALU_ADD; e.dc = 2'b10; end
        else if (opc == 7'b0010011) begin
            e.bsel = 1; e.typ = T_ALU; e.alu = base_tbl[f3];
            if (f3 == 1 && f7 != 0) ok = 0;
            if (f3 == 5 && f7 == 7'h20) e.alu = ALU_SRA;
            else if (f3 == 5 && f7 != 0) ok = 0;
        end else if (opc == 7'b0110011) begin
            e.asel = 1; e.bsel = 1; e.typ = T_ALU;
            if (f7 == 0) e.alu = base_tbl[f3];
            else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
`ifdef DEC_MEXT_EN
            else if (f7 == 7'h01) e.alu = ALU_MSTD;
`endif
            else ok = 0;
        end else if (opc == 7'b1110011) begin
            e.alu = ALU_CSR;
            if (f3 == 0) begin
                e.typ = T_IDLE;
                if (i12 == 12'h000) e.csr = 1;
                else if (i12 == 12'h001) e.csr = 2;
                else if (i12 == 12'h002) e.csr = 3;
                else if (i12 == 12'h102) e.csr = 4;
                else if (i12 == 12'h302) e.csr = 5;
                else if (i12 == 12'h105) e.csr = 6;
                else ok = 0;
            end else if (f3 == 4) ok = 0;
            else begin e.typ = T_ALU; e.csr = csr_tbl[f3]; end
        end else ok = 0;
        if (!ok) begin e = '0; e.ill = 1; end
        return e;
    endfunction

    function automatic logic [88:0] model_out();
        exp_t e;
        logic [31:0] w;
        if (mq_ins.size() == 0) return 89'd0;
        w = mq_ins[0];
        e = model_dec(w);
        return {1'b1, w, mq_pc[0], e.alu, e.dc, w[14:12], e.csr, e.jump, e.jumpr,
                e.cbr, e.typ, e.asel, e.bsel, e.ill, 3'(mq_ins.size())};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0] opcs [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
        logic [11:0] sysi [7] = '{12'h000, 12'h001, 12'h002, 12'h102, 12'h302, 12'h105, 12'h7ff};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        if (k == 10) return 32'd0;
        if (k > 10) return w;
        w[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if (k == 9 && $urandom_range(0, 1) == 1) begin
            w[14:12] = 3'd0;
            w[31:20] = sysi[$urandom_range(0, 6)];
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic do_push, do_pop;
        IN_VALID = v; IN_INS = ins; IN_PC = pc; OUT_READY = rdy; FLUSH = fl;
        #1;
        obs_rdy = IN_READY;
        exp_rdy = (mq_ins.size() < 4) && !fl;
        do_push = v && exp_rdy;
        do_pop = (mq_ins.size() > 0) && rdy;
        @(posedge CLK);
        if (fl) begin
            mq_ins.delete(); mq_pc.delete();
        end else begin
            if (do_pop) begin void'(mq_ins.pop_front()); void'(mq_pc.pop_front()); end
            if (do_push) begin mq_ins.push_back(ins); mq_pc.push_back(pc); end
        end
        #1;
    endtask

    task automatic test_reset();
        RST_N = 0; IN_VALID = 1; IN_INS = 32'h00100093; IN_PC = 32'h40;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1; IN_VALID = 0;
        mq_ins.delete(); mq_pc.delete();
        #1;
        checks++;
        if (COUNT !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        checks++;
        if (OUT_VALID !== 0) begin errors++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
        checks++;
        if (IN_READY !== 1) begin errors++; $display("FAIL reset_ready got=%b exp=1", IN_READY); end
        checks++;
        if ({ALU_CNT, CSR_CNT, TYPE, A_BUS_SEL, B_BUS_SEL, OUT_INS, OUT_PC, ILLEGAL, JUMP} !== '0) begin
            errors++;
            $display("FAIL reset_idle got alu=%0d csr=%0d type=%0d pc=%h ins=%h exp all zero",
                     ALU_CNT, CSR_CNT, TYPE, OUT_PC, OUT_INS);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc [4] = '{32'h104, 32'h108, 32'h10c, 32'h110};
        for (int i = 0; i < 4; i++)
            drive(1, 32'h00100093 + (i << 20), 32'h100 + 4 * i, 0, 0);
        checks++;
        if (COUNT !== 4) begin errors++; $display("FAIL fill_count got=%0d exp=4", COUNT); end
        checks++;
        if (IN_READY !== 0) begin errors++; $display("FAIL fill_ready got=%b exp=0", IN_READY); end
        drive(1, 32'h00500093, 32'h110, 1, 0);
        checks++;
        if (obs_rdy !== 0 || COUNT !== 3 || OUT_PC !== 32'h104) begin
            errors++;
            $display("FAIL full_pushpop rdy=%b count=%0d pc=%h exp rdy=0 count=3 pc=104",
                     obs_rdy, COUNT, OUT_PC);
        end
        drive(1, 32'h00500093, 32'h110, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (OUT_PC !== exp_pc[i]) begin
                errors++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, OUT_PC, exp_pc[i]);
            end
            drive(0, 0, 0, 1, 0);
        end
        checks++;
        if (COUNT !== 0) begin errors++; $display("FAIL fill_drain got=%0d exp=0", COUNT); end
    endtask

    task automatic test_wrap();
        drive(1, 32'h00000013, 32'h200, 0, 0);
        drive(1, 32'h00000013, 32'h204, 0, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (OUT_PC !== 32'h200 + 4 * k) begin
                errors++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, OUT_PC, 32'h200 + 4 * k);
            end
            drive(1, 32'h00000013, 32'h208 + 4 * k, 1, 0);
            checks++;
            if (COUNT !== 2) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=2", k, COUNT); end
        end
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1, 32'h00000013, 32'h300 + 4 * i, 0, 0);
        drive(1, 32'h00000013, 32'h3f0, 0, 1);
        checks++;
        if (COUNT !== 0 || OUT_VALID !== 0) begin
            errors++; $display("FAIL flush count=%0d valid=%b exp 0/0", COUNT, OUT_VALID);
        end
        drive(1, 32'h00000013, 32'h400, 0, 0);
        checks++;
        if (COUNT !== 1 || OUT_PC !== 32'h400) begin
            errors++; $display("FAIL flush_after count=%0d pc=%h exp 1/400", COUNT, OUT_PC);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_decode();
        drive(1, 32'h40208033, 32'h500, 0, 0);
        checks++;
        if (ALU_CNT !== ALU_SUB || A_BUS_SEL !== 1 || B_BUS_SEL !== 1 || TYPE !== T_ALU || ILLEGAL !== 0) begin
            errors++; $display("FAIL dec_sub alu=%0d a=%b b=%b type=%0d ill=%b exp 2/1/1/1/0",
                               ALU_CNT, A_BUS_SEL, B_BUS_SEL, TYPE, ILLEGAL);
        end
        drive(1, 32'h30200073, 32'h504, 1, 0);
        checks++;
        if (CSR_CNT !== SYS_MRET || TYPE !== T_IDLE || ALU_CNT !== ALU_CSR || ILLEGAL !== 0) begin
            errors++; $display("FAIL dec_mret csr=%0d type=%0d alu=%0d ill=%b exp 5/0/13/0",
                               CSR_CNT, TYPE, ALU_CNT, ILLEGAL);
        end
        drive(1, 32'hffffffff, 32'h508, 1, 0);
        checks++;
        if (ILLEGAL !== 1 || ALU_CNT !== ALU_IDLE || OUT_INS !== 32'hffffffff) begin
            errors++; $display("FAIL dec_ones ill=%b alu=%0d ins=%h exp 1/0/ffffffff", ILLEGAL, ALU_CNT, OUT_INS);
        end
        drive(1, 32'h00000000, 32'h50c, 1, 0);
        checks++;
        if (ILLEGAL !== 0 || OUT_VALID !== 1 || OUT_PC !== 32'h50c) begin
            errors++; $display("FAIL dec_zero ill=%b valid=%b pc=%h exp 0/1/50c", ILLEGAL, OUT_VALID, OUT_PC);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_mext();
        logic [3:0] ea;
        logic ei;
`ifdef DEC_MEXT_EN
        ea = ALU_MSTD; ei = 0;
`else
        ea = ALU_IDLE; ei = 1;
`endif
        drive(1, 32'h02208033, 32'h600, 0, 0);
        checks++;
        if (ALU_CNT !== ea || ILLEGAL !== ei) begin
            errors++; $display("FAIL mext_mul alu=%0d ill=%b exp %0d/%b", ALU_CNT, ILLEGAL, ea, ei);
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [88:0] obs, exp;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 2) != 0, rand_ins(), $urandom & 32'hfffffffc,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, obs_rdy, exp_rdy);
            end
            obs = {OUT_VALID, OUT_INS, OUT_PC, ALU_CNT, D_CACHE_CONTROL, FUN3, CSR_CNT,
                   JUMP, JUMPR, CBRANCH, TYPE, A_BUS_SEL, B_BUS_SEL, ILLEGAL, COUNT};
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rand_head[%0d] got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_decode();
        test_mext();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
